// File: rtl/tcb_peri_gpio_arb.sv
// Round-robin arbiter sharing one GPIO register bus between requesters.
// SET/CLEAR run as an uninterruptible read-modify-write sequence.
module tcb_peri_gpio_arb #(
   parameter  int REQ = 2,
   parameter  int DAT = 32,
   localparam int IDW = (REQ > 1) ? $clog2(REQ) : 1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [REQ-1:0]     req_vld,
   output logic [REQ-1:0]     req_rdy,
   input  logic [2*REQ-1:0]   req_op,
   input  logic [3*REQ-1:0]   req_adr,
   input  logic [DAT*REQ-1:0] req_dat,
   output logic               rsp_vld,
   output logic [IDW-1:0]     rsp_id,
   output logic [DAT-1:0]     rsp_rdt,
   output logic               rsp_err,
   output logic               sys_wen,
   output logic [2:0]         sys_wad,
   output logic [DAT-1:0]     sys_wdt,
   output logic               sys_ren,
   output logic [2:0]         sys_rad,
   input  logic [DAT-1:0]     sys_rdt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP
   } state_t;

   localparam logic [1:0] OP_RD  = 2'b00;
   localparam logic [1:0] OP_WR  = 2'b01;
   localparam logic [1:0] OP_SET = 2'b10;
   localparam logic [1:0] OP_CLR = 2'b11;

   state_t         state_q;
   state_t         state_d;
   logic [IDW-1:0] ptr_q;
   logic [IDW-1:0] ptr_nxt;
   logic [IDW-1:0] id_q;
   logic [1:0]     op_q;
   logic [2:0]     adr_q;
   logic [DAT-1:0] dat_q;
   logic [DAT-1:0] rdt_q;
   logic           err_q;
   logic           rmw_bad;

   logic           gnt_any;
   logic [REQ-1:0] gnt_oh;
   logic [IDW-1:0] gnt_id;
   logic [1:0]     gnt_op;
   logic [2:0]     gnt_adr;
   logic [DAT-1:0] gnt_dat;
   int             k;

   // circular first-set search starting at ptr
   always_comb begin
      gnt_any = 1'b0;
      gnt_oh  = '0;
      gnt_id  = '0;
      gnt_op  = '0;
      gnt_adr = '0;
      gnt_dat = '0;
      k       = 0;
      for (int i = 0; i < REQ; i++) begin
         k = (int'(ptr_q) + i) % REQ;
         if (!gnt_any && req_vld[k]) begin
            gnt_any   = 1'b1;
            gnt_oh[k] = 1'b1;
            gnt_id    = IDW'(k);
            gnt_op    = req_op[2*k +: 2];
            gnt_adr   = req_adr[3*k +: 3];
            gnt_dat   = req_dat[DAT*k +: DAT];
         end
      end
   end

   assign ptr_nxt = (gnt_id == IDW'(REQ-1)) ? '0 : gnt_id + IDW'(1);

   // input-data and IRQ-status registers must not be RMW targets
   assign rmw_bad = (adr_q == 3'd3) || (adr_q == 3'd7);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (gnt_any) state_d = (gnt_op == OP_WR) ? S_WRITE : S_READ;
         end
         S_READ: begin
            if (op_q == OP_RD || rmw_bad) state_d = S_RESP;
            else                          state_d = S_WRITE;
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
      endcase
   end

   // request latch, rotating pointer and read capture
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         id_q  <= '0;
         op_q  <= '0;
         adr_q <= '0;
         dat_q <= '0;
         rdt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && gnt_any) begin
            ptr_q <= ptr_nxt;
            id_q  <= gnt_id;
            op_q  <= gnt_op;
            adr_q <= gnt_adr;
            dat_q <= gnt_dat;
            rdt_q <= '0;
            err_q <= 1'b0;
         end
         if (state_q == S_READ) begin
            rdt_q <= sys_rdt;
            if (op_q != OP_RD && rmw_bad) err_q <= 1'b1;
         end
      end
   end

   // per-state bus and response outputs, all quiet during reset
   always_comb begin
      req_rdy = '0;
      rsp_vld = 1'b0;
      rsp_id  = '0;
      rsp_rdt = '0;
      rsp_err = 1'b0;
      sys_wen = 1'b0;
      sys_wad = '0;
      sys_wdt = '0;
      sys_ren = 1'b0;
      sys_rad = '0;
      if (!rst) begin
         unique case (state_q)
            S_IDLE: req_rdy = gnt_oh;
            S_READ: begin
               sys_ren = 1'b1;
               sys_rad = adr_q;
            end
            S_WRITE: begin
               sys_wen = 1'b1;
               sys_wad = adr_q;
               case (op_q)
                  OP_SET:  sys_wdt = rdt_q | dat_q;
                  OP_CLR:  sys_wdt = rdt_q & ~dat_q;
                  default: sys_wdt = dat_q;
               endcase
            end
            S_RESP: begin
               rsp_vld = 1'b1;
               rsp_id  = id_q;
               rsp_rdt = rdt_q;
               rsp_err = err_q;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tcb_peri_gpio_arb.sv
// Directed bench for tcb_peri_gpio_arb with a small GPIO register model.
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_tcb_peri_gpio_arb;

   localparam int REQ = 3;
   localparam int DAT = 32;
   localparam int IDW = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [REQ-1:0]     req_vld;
   logic [REQ-1:0]     req_rdy;
   logic [2*REQ-1:0]   req_op;
   logic [3*REQ-1:0]   req_adr;
   logic [DAT*REQ-1:0] req_dat;
   logic               rsp_vld;
   logic [IDW-1:0]     rsp_id;
   logic [DAT-1:0]     rsp_rdt;
   logic               rsp_err;
   logic               sys_wen;
   logic [2:0]         sys_wad;
   logic [DAT-1:0]     sys_wdt;
   logic               sys_ren;
   logic [2:0]         sys_rad;
   logic [DAT-1:0]     sys_rdt;

   logic               pre_en;
   logic [2:0]         pre_adr;
   logic [DAT-1:0]     pre_dat;
   logic [DAT-1:0]     mem [8];

   int                 n_tot = 0;
   int                 n_pass = 0;

   always #5 clk = ~clk;

   tcb_peri_gpio_arb #(.REQ(REQ), .DAT(DAT)) dut (
      .clk     (clk),
      .rst     (rst),
      .req_vld (req_vld),
      .req_rdy (req_rdy),
      .req_op  (req_op),
      .req_adr (req_adr),
      .req_dat (req_dat),
      .rsp_vld (rsp_vld),
      .rsp_id  (rsp_id),
      .rsp_rdt (rsp_rdt),
      .rsp_err (rsp_err),
      .sys_wen (sys_wen),
      .sys_wad (sys_wad),
      .sys_wdt (sys_wdt),
      .sys_ren (sys_ren),
      .sys_rad (sys_rad),
      .sys_rdt (sys_rdt)
   );

   // GPIO model: address 3 is read-only, everything else stores writes
   always @(posedge clk) begin
      if (pre_en)                      mem[pre_adr] <= pre_dat;
      else if (sys_wen && sys_wad != 3) mem[sys_wad] <= sys_wdt;
   end

   assign sys_rdt = mem[sys_rad];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   task automatic setreq(input int i, input logic [1:0] op,
                         input logic [2:0] a, input logic [31:0] d);
      req_vld[i]          = 1'b1;
      req_op[2*i +: 2]    = op;
      req_adr[3*i +: 3]   = a;
      req_dat[32*i +: 32] = d;
   endtask

   task automatic quiet_chk(input string tag);
      chk({tag, "_wen"}, 32'(sys_wen), 0);
      chk({tag, "_ren"}, 32'(sys_ren), 0);
      chk({tag, "_rsp"}, 32'(rsp_vld), 0);
      chk({tag, "_rdy"}, 32'(req_rdy), 0);
   endtask

   initial begin
      logic [31:0] pre_tab [8];
      pre_tab = '{32'h0, 32'hA5, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0, 32'h4};
      rst     = 1'b1;
      req_vld = '0;
      req_op  = '0;
      req_adr = '0;
      req_dat = '0;
      pre_en  = 1'b0;
      pre_adr = '0;
      pre_dat = '0;

      // preload model while reset holds the DUT idle
      for (int i = 0; i < 8; i++) begin
         nxt;
         pre_en  = 1'b1;
         pre_adr = 3'(i);
         pre_dat = pre_tab[i];
         req_vld = 3'b111;
         smp;
         chk("rst_rdy", 32'(req_rdy), 0);
      end
      nxt;
      pre_en  = 1'b0;
      req_vld = '0;
      smp;
      quiet_chk("rst");
      chk("rst_id", 32'(rsp_id), 0);
      chk("rst_rdt", rsp_rdt, 0);
      chk("rst_wdt", sys_wdt, 0);
      rst = 1'b0;

      // single READ adr 1
      nxt; setreq(0, 2'b00, 3'd1, 32'h0);
      smp; chk("rd_rdy", 32'(req_rdy), 3'b001);
      nxt; req_vld = '0;
      smp; chk("rd_ren", 32'(sys_ren), 1);
      chk("rd_rad", 32'(sys_rad), 1);
      chk("rd_rsp_early", 32'(rsp_vld), 0);
      nxt;
      smp; chk("rd_rsp", 32'(rsp_vld), 1);
      chk("rd_rdt", rsp_rdt, 32'hA5);
      chk("rd_id", 32'(rsp_id), 0);
      chk("rd_err", 32'(rsp_err), 0);

      // set od to 0x0F, then SET 0x30
      nxt; pre_en = 1'b1; pre_adr = 3'd1; pre_dat = 32'h0F;
      smp;
      nxt; pre_en = 1'b0; setreq(0, 2'b10, 3'd1, 32'h30);
      smp; chk("set_rdy", 32'(req_rdy), 3'b001);
      nxt; req_vld = '0;
      smp; chk("set_ren", 32'(sys_ren), 1);
      chk("set_wen0", 32'(sys_wen), 0);
      nxt;
      smp; chk("set_wen", 32'(sys_wen), 1);
      chk("set_wad", 32'(sys_wad), 1);
      chk("set_wdt", sys_wdt, 32'h3F);
      chk("set_ren1", 32'(sys_ren), 0);
      nxt;
      smp; chk("set_rsp", 32'(rsp_vld), 1);
      chk("set_rdt", rsp_rdt, 32'h0F);
      chk("set_od", mem[1], 32'h3F);

      // CLEAR 0x05
      nxt; setreq(0, 2'b11, 3'd1, 32'h05);
      smp; chk("clr_rdy", 32'(req_rdy), 3'b001);
      nxt; req_vld = '0;
      smp;
      nxt;
      smp; chk("clr_wdt", sys_wdt, 32'h3A);
      nxt;
      smp; chk("clr_rdt", rsp_rdt, 32'h3F);

      // rejected SET on IRQ status
      nxt; setreq(0, 2'b10, 3'd7, 32'h1);
      smp; chk("rej_rdy", 32'(req_rdy), 3'b001);
      nxt; req_vld = '0;
      smp; chk("rej_ren", 32'(sys_ren), 1);
      chk("rej_rad", 32'(sys_rad), 7);
      nxt;
      smp; chk("rej_wen", 32'(sys_wen), 0);
      chk("rej_rsp", 32'(rsp_vld), 1);
      chk("rej_err", 32'(rsp_err), 1);
      chk("rej_rdt", rsp_rdt, 32'h4);

      // plain WRITE to IRQ status passes through
      nxt; setreq(0, 2'b01, 3'd7, 32'h1);
      smp; chk("w7_rdy", 32'(req_rdy), 3'b001);
      nxt; req_vld = '0;
      smp; chk("w7_wen", 32'(sys_wen), 1);
      chk("w7_wad", 32'(sys_wad), 7);
      chk("w7_wdt", sys_wdt, 32'h1);
      nxt;
      smp; chk("w7_rsp", 32'(rsp_vld), 1);
      chk("w7_err", 32'(rsp_err), 0);
      chk("w7_rdt", rsp_rdt, 0);

      // atomicity: requester 1 writes while requester 0 SET runs
      nxt; setreq(0, 2'b10, 3'd1, 32'h40);
      smp; chk("at_rdy0", 32'(req_rdy), 3'b001);
      nxt; req_vld[0] = 1'b0; setreq(1, 2'b01, 3'd1, 32'h55);
      smp; chk("at_blk1", 32'(req_rdy), 0);
      nxt;
      smp; chk("at_blk2", 32'(req_rdy), 0);
      chk("at_wdt0", sys_wdt, 32'h7A);
      nxt;
      smp; chk("at_blk3", 32'(req_rdy), 0);
      chk("at_id0", 32'(rsp_id), 0);
      chk("at_rsp0", 32'(rsp_vld), 1);
      nxt;
      smp; chk("at_rdy1", 32'(req_rdy), 3'b010);
      nxt; req_vld = '0;
      smp; chk("at_wdt1", sys_wdt, 32'h55);
      nxt;
      smp; chk("at_id1", 32'(rsp_id), 1);
      chk("at_od", mem[1], 32'h55);

      // reset during the READ phase of a SET
      nxt; setreq(0, 2'b10, 3'd1, 32'hFF0);
      smp; chk("mr_rdy", 32'(req_rdy), 3'b001);
      nxt; req_vld = '0; rst = 1'b1;
      smp; quiet_chk("mr_in");
      nxt; rst = 1'b0;
      smp; quiet_chk("mr_a1");
      nxt;
      smp; quiet_chk("mr_a2");
      chk("mr_od", mem[1], 32'h55);

      // round-robin with all requesters held
      nxt;
      setreq(0, 2'b00, 3'd1, 32'h0);
      setreq(1, 2'b00, 3'd2, 32'h0);
      setreq(2, 2'b00, 3'd0, 32'h0);
      for (int c = 0; c < 12; c++) begin
         smp;
         case (c)
            0: chk("rr_g0", 32'(req_rdy), 3'b001);
            3: chk("rr_g1", 32'(req_rdy), 3'b010);
            6: chk("rr_g2", 32'(req_rdy), 3'b100);
            9: chk("rr_g0b", 32'(req_rdy), 3'b001);
            default: chk("rr_idle", 32'(req_rdy), 0);
         endcase
         if (c == 2) begin
            chk("rr_id0", 32'(rsp_id), 0);
            chk("rr_rdt0", rsp_rdt, 32'h55);
         end
         if (c == 5) begin
            chk("rr_id1", 32'(rsp_id), 1);
            chk("rr_rdt1", rsp_rdt, 32'h22);
         end
         if (c == 8) chk("rr_id2", 32'(rsp_id), 2);
         nxt;
      end
      req_vld = '0;
      nxt;
      nxt;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/tcb_peri_gpio_arb.md
Name: tcb_peri_gpio_arb

Overview:
- Round-robin arbiter and sequencer that shares one GPIO controller system bus (8-register map, 3-bit address) between REQ requesters.
- Offers atomic READ, WRITE, SET-bits and CLEAR-bits operations. SET and CLEAR are executed as an uninterruptible read-modify-write, so concurrent software agents cannot corrupt shared registers such as output data or output enable.
- Sits between CPU-side/DMA-side bus agents and the GPIO peripheral's sys_* interface.

Parameters:
- REQ, 2, number of requesters (1..8).
- DAT, 32, system data width; must match the GPIO controller's SYS_DAT.
- IDW, $clog2(REQ) clamped to a minimum of 1, width of the response requester ID (localparam).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- req_vld  input  REQ  per-requester request valid
- req_rdy  output  REQ  per-requester accept; one-hot or zero
- req_op  input  2*REQ  per-requester operation: 00 READ, 01 WRITE, 10 SET, 11 CLEAR
- req_adr  input  3*REQ  per-requester register address
- req_dat  input  DAT*REQ  per-requester write data or bit mask
- rsp_vld  output  1  response valid, single-cycle pulse
- rsp_id  output  IDW  index of the requester being answered
- rsp_rdt  output  DAT  register value read before any modification
- rsp_err  output  1  operation rejected
- sys_wen  output  1  GPIO write enable
- sys_wad  output  3  GPIO write address
- sys_wdt  output  DAT  GPIO write data
- sys_ren  output  1  GPIO read enable
- sys_rad  output  3  GPIO read address
- sys_rdt  input  DAT  GPIO read data; combinational from sys_rad in the same cycle

Behaviour:
- Configuration is the default: one clock domain, with reset synchronous and active-high on `rst`.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - If any req_vld is set, grant the first set bit searching circularly from ptr.
  - Assert req_rdy[g] for that cycle only.
  - Latch op, adr, dat and id=g.
  - Next state is WRITE for op WRITE, otherwise READ.
  - Set ptr = (g+1) mod REQ.
- READ:
  - sys_ren=1, sys_rad=adr.
  - Capture sys_rdt into rdt_q at the end of the cycle.
  - Op READ goes to RESP. Op SET/CLEAR goes to WRITE, except a SET/CLEAR to address 3 (input data) or 7 (IRQ status), which sets err and goes to RESP with no write.
- WRITE:
  - sys_wen=1, sys_wad=adr.
  - sys_wdt is dat for WRITE, rdt_q | dat for SET, rdt_q & ~dat for CLEAR.
  - Next state is RESP.
- WRITE to address 7 passes through unmodified; it is the IRQ clear pulse. WRITE to address 3 is issued; the GPIO controller ignores it; err=0.
- RESP:
  - rsp_vld=1 for exactly one cycle.
  - rsp_id=id, rsp_rdt=rdt_q (0 for WRITE), rsp_err=err.
  - Next state is IDLE. No response backpressure.
- Latency from the accept cycle T: READ responds at T+2; WRITE writes at T+1 and responds at T+2; SET/CLEAR reads at T+1, writes at T+2, responds at T+3.
- Throughput: a new accept is possible only in IDLE. Requests arriving during an operation wait with req_vld held; requesters must keep req_* stable until req_rdy.
- When not in the corresponding state, sys_wen=0, sys_ren=0, and sys_wad, sys_rad, sys_wdt are 0.
- Fairness: every continuously requesting agent is granted within REQ operations.
- Simultaneous req_vld on all bits with ptr=k: grant k.
- Dropping req_vld before req_rdy withdraws the request without side effects.
- Reset, including reset mid-operation:
  - State returns to IDLE and ptr=0; any pending write is aborted, so no sys_wen is issued after the reset cycle.
  - req_rdy=0, rsp_vld=0, rsp_id=0, rsp_rdt=0, rsp_err=0, sys_*=0.
  - Latched fields are cleared.
- Only the REQ==1 case degenerates: ptr is constant 0 and IDW=1.

Test Plan:
- Single READ: requester 0 issues READ adr=1 while the GPIO model has od=0x0000_00A5 -> req_rdy[0] at T, sys_ren/rad=1 at T+1, rsp_vld at T+2 with rdt=0xA5, id=0, err=0.
- SET then CLEAR: od=0x0F, SET adr=1 dat=0x30 -> sys_wdt=0x3F at T+2, rsp_rdt=0x0F at T+3. Then CLEAR dat=0x05 -> sys_wdt=0x3A.
- Round-robin: REQ=3, all three req_vld held high from reset -> grant order 0,1,2,0. Each req_rdy is a single-cycle pulse, with no overlap between consecutive operations.
- Rejected RMW: SET adr=7 dat=0x1 -> one read at adr 7, no sys_wen, rsp_err=1. WRITE adr=7 dat=0x1 -> sys_wen with wdt=0x1, err=0.
- Reset mid-RMW: assert rst during the READ state of a SET -> no sys_wen afterwards, no rsp_vld, all outputs 0. The next request after reset is granted to requester 0 first.
- Atomicity: requester 1 posts WRITE adr=1 while requester 0's SET is in flight -> requester 1's write appears only after requester 0's RESP, and the final od equals requester 1's data.
